fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Control-side sequencer that sits directly upstream of the addressing unit. It drives every PC-update select (ResetPC, PCplusI, PCplus1, RplusI, Rplus0, PCenable) and the immediate byte (Iside). It also runs the instruction-fetch handshake with memory, holds the instruction register, resolves jumps/branches locally, and hands all other instructions to the execution unit through a req/ack handshake.

## Interface
- HALT_ON_UNKNOWN, 0: selects the response to an undefined branch sub-op.
  - 0: treat it as NOP.
  - 1: enter HALT.
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- MemData  in  16  instruction word from memory
- MemReady  in  1  memory data valid; sampled only while ReadMem=1
- Cflag, Zflag  in  1 each  datapath flags, sampled in BRANCH
- ExecAck  in  1  execution unit done; sampled only while ExecReq=1
- ReadMem  out  1  fetch request to memory
- ExecReq  out  1  execute request for current IR
- IRout  out  16  instruction register
- Iside  out  8  immediate = IR[7:0]
- ResetPC, PCplusI, PCplus1, RplusI, Rplus0  out  1 each  address-select strobes; at most one high in any cycle
- PCenable  out  1  PC load strobe
- Halted  out  1  high in HALT

## Operation
- Decode fields:
  - op = IR[15:12]
  - sub = IR[11:8]
- op 0x0:
  - sub 0x0 = NOP
  - sub 0x1 = HLT
  - any other sub = NOP
- op 0xF is the branch class:
  - sub 0 JPR: PC←Rside (Rplus0)
  - sub 1 JPA: PC←Rside+I (RplusI)
  - sub 2 JREL: PC←PC+I (PCplusI)
  - sub 3 BRC: PC+I if Cflag, else PC+1
  - sub 4 BRZ: PC+I if Zflag, else PC+1
  - sub 5..F: handled per HALT_ON_UNKNOWN
- All other op values are EXEC class.
- FSM states: S_RESET, S_FETCH, S_DECODE, S_EXEC, S_BRANCH, S_INCPC, S_HALT.
- State transitions:
  - S_RESET → S_FETCH unconditionally.
    - Outputs: ResetPC=1, PCenable=1.
  - S_FETCH holds while MemReady=0. When MemReady=1: IR←MemData, → S_DECODE.
    - Outputs: ReadMem=1.
  - S_DECODE → S_INCPC (NOP), S_HALT (HLT), S_BRANCH (branch class), or S_EXEC (EXEC class).
    - Outputs: none asserted.
  - S_EXEC holds while ExecAck=0. ExecAck=1 → S_INCPC.
    - Outputs: ExecReq=1.
  - S_BRANCH → S_FETCH.
    - Outputs: the selected strobe plus PCenable=1.
  - S_INCPC → S_FETCH.
    - Outputs: PCplus1=1, PCenable=1.
  - S_HALT is terminal; exit only via rst_n.
    - Outputs: Halted=1, all strobes 0.
- Outputs are Moore functions of state and IR only. MemReady, ExecAck and flags never reach outputs combinationally; flags only affect which strobe is driven in S_BRANCH.
- Reset values, valid while rst_n=0 and in S_RESET:
  - state=S_RESET, IR=0x0000, Iside=0x00
  - ResetPC=1, PCenable=1
  - all other outputs 0

## Timing
- Minimum cycles per instruction with MemReady high on first fetch cycle:
  - NOP: 3 (FETCH, DECODE, INCPC)
  - branch: 3
  - EXEC: 4 + ack wait
- Each memory wait cycle adds 1.
- IR updates only on the clock edge that leaves S_FETCH. IRout/Iside are stable from S_DECODE until the next fetch completes.
- MemReady high outside S_FETCH and ExecAck high outside S_EXEC are ignored.
- Flags are sampled in the S_BRANCH cycle, not in S_DECODE.
- The PC wraps 0xFFFF→0x0000 in the addressing unit; the sequencer needs no special case.
- rst_n assertion in any state forces S_RESET immediately and asynchronously:
  - ReadMem and ExecReq drop without waiting for ack.
  - IR clears.
- On rst_n release, the first rising edge moves to S_FETCH. PC is 0 at the first fetch.

## Structure
- Package sayeh_ctrl_pkg holds:
  - state enum
  - op/sub encodings: OP_SYS=4'h0, OP_BR=4'hF, SUB_NOP, SUB_HLT, SUB_JPR, SUB_JPA, SUB_JREL, SUB_BRC, SUB_BRZ
  - instruction-class enum {CL_NOP, CL_HLT, CL_BR, CL_EXEC, CL_UNK}
- One combinational sub-module, fetch_decode: IR in, class and branch-select out. The FSM, IR register and output decode live in fetch_sequencer.

## Test plan
- Reset, NOP fetch:
  - Stimulus: hold rst_n=0 3 cycles (check ResetPC=PCenable=1, IR=0); release; MemData=0x0000 with MemReady=1.
  - Required: ReadMem 1 cycle, then DECODE, then PCplus1+PCenable 1 cycle, back to FETCH.
- Memory wait:
  - Stimulus: MemReady low 4 cycles, then high with MemData=0xF27F.
  - Required: ReadMem high 5 cycles; IR=0xF27F; Iside=0x7F; in BRANCH, PCplusI=1 and PCenable=1.
- Conditional branch:
  - Stimulus: IR=0xF305 with Cflag=0.
  - Required: PCplus1 only.
  - Stimulus: IR=0xF305 with Cflag=1.
  - Required: PCplusI only.
  - Stimulus: IR=0xF405 with Zflag=1.
  - Required: PCplusI only.
- Exec handshake:
  - Stimulus: IR=0x1234; ExecAck after 3 cycles; a stray ExecAck pulse during FETCH.
  - Required: ExecReq held exactly until ack, then INCPC; stray ack has no effect.
- Halt and unknown sub-op:
  - Stimulus: IR=0x0100.
  - Required: Halted=1 indefinitely, all strobes 0.
  - Stimulus: IR=0xF900 with HALT_ON_UNKNOWN=0.
  - Required: PCplus1.
  - Stimulus: IR=0xF900 with HALT_ON_UNKNOWN=1.
  - Required: Halted=1.
- Reset mid-operation:
  - Stimulus: drop rst_n mid-S_EXEC and mid-S_FETCH, asynchronously between edges.
  - Required: ExecReq/ReadMem go 0 and ResetPC goes 1 before the next edge; one-hot strobe check holds throughout.

Source files
------------

// File: rtl/sayeh_ctrl_pkg.sv
// Shared encodings for the fetch sequencer: FSM states, opcode fields and
// the instruction classes the decoder hands back to the FSM.
package sayeh_ctrl_pkg;

  typedef enum logic [2:0] {
    S_RESET,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_BRANCH,
    S_INCPC,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_SYS   = 4'h0;
  localparam logic [3:0] OP_BR    = 4'hF;
  localparam logic [3:0] SUB_NOP  = 4'h0;
  localparam logic [3:0] SUB_HLT  = 4'h1;
  localparam logic [3:0] SUB_JPR  = 4'h0;
  localparam logic [3:0] SUB_JPA  = 4'h1;
  localparam logic [3:0] SUB_JREL = 4'h2;
  localparam logic [3:0] SUB_BRC  = 4'h3;
  localparam logic [3:0] SUB_BRZ  = 4'h4;

  typedef enum logic [2:0] {
    CL_NOP,
    CL_HLT,
    CL_BR,
    CL_EXEC,
    CL_UNK
  } iclass_t;

  // Which address strobe a branch-class instruction wants; BS_BRC/BS_BRZ
  // are resolved against the flags only when the FSM is in S_BRANCH.
  typedef enum logic [2:0] {
    BS_R0,
    BS_RI,
    BS_PCI,
    BS_BRC,
    BS_BRZ,
    BS_NONE
  } br_sel_t;

endpackage

// File: rtl/fetch_decode.sv
// Pure combinational classifier of the instruction register.
module fetch_decode
  import sayeh_ctrl_pkg::*;
(
  input  logic [15:0] ir,
  output iclass_t     iclass,
  output br_sel_t     br_sel
);

  logic [3:0] op;
  logic [3:0] sub;

  assign op  = ir[15:12];
  assign sub = ir[11:8];

  // Map op/sub to an instruction class and, for branches, the target select.
  // NOTE: every output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    iclass = CL_EXEC;
    br_sel = BS_NONE;
    if (op == OP_SYS) begin
      iclass = (sub == SUB_HLT) ? CL_HLT : CL_NOP;
    end else if (op == OP_BR) begin
      iclass = CL_BR;
      case (sub)
        SUB_JPR:  br_sel = BS_R0;
        SUB_JPA:  br_sel = BS_RI;
        SUB_JREL: br_sel = BS_PCI;
        SUB_BRC:  br_sel = BS_BRC;
        SUB_BRZ:  br_sel = BS_BRZ;
        default:  iclass = CL_UNK;
      endcase
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/decode/dispatch sequencer driving the PC-update strobes of the
// addressing unit, the memory fetch handshake and the execute handshake.
module fetch_sequencer
  import sayeh_ctrl_pkg::*;
#(
  parameter bit HALT_ON_UNKNOWN = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] MemData,
  input  logic        MemReady,
  input  logic        Cflag,
  input  logic        Zflag,
  input  logic        ExecAck,
  output logic        ReadMem,
  output logic        ExecReq,
  output logic [15:0] IRout,
  output logic [7:0]  Iside,
  output logic        ResetPC,
  output logic        PCplusI,
  output logic        PCplus1,
  output logic        RplusI,
  output logic        Rplus0,
  output logic        PCenable,
  output logic        Halted
);

  state_t  state;
  state_t  next_state;
  iclass_t iclass;
  br_sel_t br_sel;
  logic [15:0] ir;

  fetch_decode u_decode (
    .ir     (ir),
    .iclass (iclass),
    .br_sel (br_sel)
  );

  assign IRout = ir;
  assign Iside = ir[7:0];

  // State register; reset drops straight into S_RESET between edges.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_RESET;
    else        state <= next_state;
  end

  // Instruction register, loaded only on the edge that completes a fetch.
  // NOTE: IR is a single control register, so it is cleared by reset; this
  // does not extend to RAM-style arrays, which are left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          ir <= '0;
    else if (state == S_FETCH && MemReady) ir <= MemData;
  end

  // Next-state and Moore output decode; flags only steer the branch strobe.
  always_comb begin
    next_state = state;
    ReadMem    = 1'b0;
    ExecReq    = 1'b0;
    ResetPC    = 1'b0;
    PCplusI    = 1'b0;
    PCplus1    = 1'b0;
    RplusI     = 1'b0;
    Rplus0     = 1'b0;
    PCenable   = 1'b0;
    Halted     = 1'b0;
    case (state)
      S_RESET: begin
        ResetPC    = 1'b1;
        PCenable   = 1'b1;
        next_state = S_FETCH;
      end
      S_FETCH: begin
        ReadMem = 1'b1;
        if (MemReady) next_state = S_DECODE;
      end
      S_DECODE: begin
        case (iclass)
          CL_NOP:  next_state = S_INCPC;
          CL_HLT:  next_state = S_HALT;
          CL_BR:   next_state = S_BRANCH;
          CL_UNK:  next_state = HALT_ON_UNKNOWN ? S_HALT : S_INCPC;
          default: next_state = S_EXEC;
        endcase
      end
      S_EXEC: begin
        ExecReq = 1'b1;
        if (ExecAck) next_state = S_INCPC;
      end
      S_BRANCH: begin
        PCenable   = 1'b1;
        next_state = S_FETCH;
        case (br_sel)
          BS_R0:   Rplus0 = 1'b1;
          BS_RI:   RplusI = 1'b1;
          BS_PCI:  PCplusI = 1'b1;
          BS_BRC:  if (Cflag) PCplusI = 1'b1; else PCplus1 = 1'b1;
          BS_BRZ:  if (Zflag) PCplusI = 1'b1; else PCplus1 = 1'b1;
          default: PCplus1 = 1'b1;
        endcase
      end
      S_INCPC: begin
        PCplus1    = 1'b1;
        PCenable   = 1'b1;
        next_state = S_FETCH;
      end
      S_HALT: begin
        Halted = 1'b1;
      end
      default: next_state = S_RESET;
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a retirement scoreboard.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] MemData;
  logic        MemReady, Cflag, Zflag, ExecAck;
  logic        ReadMem, ExecReq, ResetPC, PCplusI, PCplus1, RplusI, Rplus0, PCenable, Halted;
  logic [15:0] IRout;
  logic [7:0]  Iside;
  logic        h_ReadMem, h_ExecReq, h_ResetPC, h_PCplusI, h_PCplus1, h_RplusI, h_Rplus0, h_PCenable, h_Halted;
  logic [15:0] h_IRout;
  logic [7:0]  h_Iside;

  fetch_sequencer #(.HALT_ON_UNKNOWN(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .MemData(MemData), .MemReady(MemReady),
    .Cflag(Cflag), .Zflag(Zflag), .ExecAck(ExecAck),
    .ReadMem(ReadMem), .ExecReq(ExecReq), .IRout(IRout), .Iside(Iside),
    .ResetPC(ResetPC), .PCplusI(PCplusI), .PCplus1(PCplus1), .RplusI(RplusI),
    .Rplus0(Rplus0), .PCenable(PCenable), .Halted(Halted)
  );

  // Second copy that halts on unknown branch sub-ops; shares all stimulus.
  fetch_sequencer #(.HALT_ON_UNKNOWN(1'b1)) dut_h (
    .clk(clk), .rst_n(rst_n), .MemData(MemData), .MemReady(MemReady),
    .Cflag(Cflag), .Zflag(Zflag), .ExecAck(ExecAck),
    .ReadMem(h_ReadMem), .ExecReq(h_ExecReq), .IRout(h_IRout), .Iside(h_Iside),
    .ResetPC(h_ResetPC), .PCplusI(h_PCplusI), .PCplus1(h_PCplus1), .RplusI(h_RplusI),
    .Rplus0(h_Rplus0), .PCenable(h_PCenable), .Halted(h_Halted)
  );

  always #5 clk = ~clk;

  // {ReadMem, ExecReq, Halted, ResetPC, PCplusI, PCplus1, RplusI, Rplus0, PCenable}
  localparam logic [8:0] V_RESET = 9'b000100001;
  localparam logic [8:0] V_FETCH = 9'b100000000;
  localparam logic [8:0] V_DEC   = 9'b000000000;
  localparam logic [8:0] V_EXEC  = 9'b010000000;
  localparam logic [8:0] V_INC   = 9'b000001001;
  localparam logic [8:0] V_PCI   = 9'b000010001;
  localparam logic [8:0] V_RI    = 9'b000000101;
  localparam logic [8:0] V_R0    = 9'b000000011;
  localparam logic [8:0] V_HALT  = 9'b001000000;

  logic [8:0] obs, h_obs;
  assign obs   = {ReadMem, ExecReq, Halted, ResetPC, PCplusI, PCplus1, RplusI, Rplus0, PCenable};
  assign h_obs = {h_ReadMem, h_ExecReq, h_Halted, h_ResetPC, h_PCplusI, h_PCplus1,
                  h_RplusI, h_Rplus0, h_PCenable};

  typedef struct packed {
    logic [15:0] ir;
    logic [8:0]  vec;
  } retire_t;

  retire_t sb[$];
  retire_t exp_r;
  int n_checks = 0;
  int n_errors = 0;

  // Expected strobes on the retiring cycle of an instruction (no halts here).
  function automatic logic [8:0] model_retire(input logic [15:0] w, input logic c, input logic z);
    logic [3:0] op, sub;
    op  = w[15:12];
    sub = w[11:8];
    if (op != 4'hF) return V_INC;
    case (sub)
      4'h0:    return V_R0;
      4'h1:    return V_RI;
      4'h2:    return V_PCI;
      4'h3:    return c ? V_PCI : V_INC;
      4'h4:    return z ? V_PCI : V_INC;
      default: return V_INC;
    endcase
  endfunction

  task automatic chk_vec(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: outputs=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Scoreboard: every PC-load outside reset retires the oldest queued entry.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && PCenable === 1'b1 && ResetPC === 1'b0) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $error("FAIL retire_unexpected: ir=%h outputs=%b expected=no retirement", IRout, obs);
      end else begin
        exp_r = sb.pop_front();
        n_checks++;
        assert ({IRout, obs} === {exp_r.ir, exp_r.vec}) else begin
          n_errors++;
          $error("FAIL retire: ir=%h outputs=%b expected ir=%h outputs=%b",
                 IRout, obs, exp_r.ir, exp_r.vec);
        end
      end
    end
    n_checks++;
    assert ($countones({ResetPC, PCplusI, PCplus1, RplusI, Rplus0}) <= 1) else begin
      n_errors++;
      $error("FAIL onehot: strobes=%b expected at most one high",
             {ResetPC, PCplusI, PCplus1, RplusI, Rplus0});
    end
  end

  // Drop reset offset ns after the current point, check the asynchronous
  // response before the next edge, hold 3 cycles, release, expect FETCH.
  task automatic do_reset(input string tag, input int offset);
    #(offset);
    rst_n = 1'b0;
    #1;
    chk_vec({tag, "_async"}, obs, V_RESET);
    chk16({tag, "_ir_clear"}, IRout, 16'h0000);
    chk16({tag, "_iside_clear"}, {8'h00, Iside}, 16'h0000);
    sb.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_vec({tag, "_held"}, obs, V_RESET);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk_vec({tag, "_first_fetch"}, obs, V_FETCH);
  endtask

  // Starts at a negedge in FETCH, ends at the negedge of the DECODE cycle.
  task automatic fetch_word(input string tag, input logic [15:0] w, input int waits);
    MemReady = 1'b0;
    for (int i = 0; i < waits; i++) begin
      chk_vec({tag, "_wait"}, obs, V_FETCH);
      @(negedge clk);
    end
    MemData  = w;
    MemReady = 1'b1;
    chk_vec({tag, "_fetch"}, obs, V_FETCH);
    @(negedge clk);
    MemReady = 1'b0;
    MemData  = 16'hDEAD;
    chk_vec({tag, "_decode"}, obs, V_DEC);
    chk16({tag, "_ir"}, IRout, w);
    chk16({tag, "_iside"}, {8'h00, Iside}, {8'h00, w[7:0]});
  endtask

  // NOP or branch; flags are inverted during fetch and set only in DECODE,
  // so the strobe must reflect the value present in the BRANCH cycle.
  task automatic run_simple(input string tag, input logic [15:0] w, input int waits,
                            input logic c, input logic z);
    Cflag = ~c;
    Zflag = ~z;
    fetch_word(tag, w, waits);
    Cflag = c;
    Zflag = z;
    sb.push_back('{ir: w, vec: model_retire(w, c, z)});
    @(negedge clk);
    @(negedge clk);
    chk_vec({tag, "_back_to_fetch"}, obs, V_FETCH);
  endtask

  task automatic run_exec(input string tag, input logic [15:0] w, input int ack_delay);
    fetch_word(tag, w, 0);
    sb.push_back('{ir: w, vec: V_INC});
    @(negedge clk);
    for (int i = 0; i < ack_delay; i++) begin
      MemReady = 1'b1;
      MemData  = 16'hFFFF;
      chk_vec({tag, "_req_wait"}, obs, V_EXEC);
      @(negedge clk);
    end
    MemReady = 1'b0;
    ExecAck  = 1'b1;
    chk_vec({tag, "_req_ack"}, obs, V_EXEC);
    @(negedge clk);
    ExecAck = 1'b0;
    chk16({tag, "_ir_stable"}, IRout, w);
    @(negedge clk);
    chk_vec({tag, "_back_to_fetch"}, obs, V_FETCH);
  endtask

  initial begin
    #200000;
    $error("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; MemData = 16'h0000; MemReady = 1'b0;
    Cflag = 1'b0; Zflag = 1'b0; ExecAck = 1'b0;

    do_reset("rst_init", 0);

    run_simple("nop", 16'h0000, 0, 1'b0, 1'b0);
    run_simple("jrel_wait", 16'hF27F, 4, 1'b0, 1'b0);
    run_simple("brc_c0", 16'hF305, 0, 1'b0, 1'b0);
    run_simple("brc_c1", 16'hF305, 0, 1'b1, 1'b0);
    run_simple("brz_z1", 16'hF405, 0, 1'b0, 1'b1);
    run_simple("brz_z0", 16'hF405, 1, 1'b0, 1'b0);
    run_simple("jpr", 16'hF0AA, 0, 1'b0, 1'b0);
    run_simple("jpa", 16'hF155, 2, 1'b0, 1'b0);
    run_simple("nop_sub7", 16'h0700, 0, 1'b0, 1'b0);

    run_exec("exec", 16'h1234, 3);
    ExecAck = 1'b1;
    run_simple("stray_ack", 16'h0000, 2, 1'b0, 1'b0);
    ExecAck = 1'b0;
    run_exec("exec_fast", 16'h7ABC, 0);

    fetch_word("unk", 16'hF900, 0);
    sb.push_back('{ir: 16'hF900, vec: model_retire(16'hF900, 1'b0, 1'b0)});
    @(negedge clk);
    chk_vec("unk_halt_variant", h_obs, V_HALT);
    @(negedge clk);
    chk_vec("unk_back_to_fetch", obs, V_FETCH);
    chk_vec("unk_halt_variant_stays", h_obs, V_HALT);

    fetch_word("hlt", 16'h0100, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      MemReady = i[0];
      ExecAck  = ~i[0];
      chk_vec("hlt_hold", obs, V_HALT);
    end
    MemReady = 1'b0;
    ExecAck  = 1'b0;
    @(negedge clk);
    do_reset("rst_halt", 2);

    fetch_word("rst_exec_instr", 16'h2345, 0);
    @(negedge clk);
    chk_vec("rst_exec_in_exec", obs, V_EXEC);
    do_reset("rst_exec", 2);

    MemReady = 1'b0;
    @(negedge clk);
    chk_vec("rst_fetch_in_fetch", obs, V_FETCH);
    do_reset("rst_fetch", 3);
    chk_vec("rst_fetch_variant_fetch", h_obs, V_FETCH);

    run_simple("post_rst_nop", 16'h0000, 0, 1'b0, 1'b0);
    run_simple("post_rst_unk", 16'hFF12, 0, 1'b1, 1'b1);

    n_checks++;
    assert (sb.size() == 0) else begin
      n_errors++;
      $error("FAIL sb_drain: pending=%0d expected=0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
